debug_unit: RTL and testbench
=============================

# debug_unit

Host-side controller that sequences the MIPS pipeline for bring-up on the Nexys3. It sits between the UART (byte-level rx/tx strobes) and the pipeline top. It loads a program into instruction memory through the pipeline's debug write port, then runs the pipeline either continuously until halt or one clock per step. After each run or step it returns a 5-byte status report (PC, register 1) to the host.

## Interface
Parameters:
- len_data, 32, pipeline data / instruction width
- len_addr, 11, instruction memory address width
- len_byte, 8, UART byte width

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- rx_data  in  len_byte  received byte, valid when rx_done=1
- rx_done  in  1  one-cycle strobe, new byte on rx_data
- tx_done  in  1  one-cycle strobe, UART finished previous byte
- halt_flag  in  1  pipeline halt, from writeback stage
- in_pc  in  8  pipeline PC low byte
- in_reg1  in  len_data  register 1 value from register file
- debug_flag  out  1  1 = debug unit owns instruction memory port / pipeline frozen
- mips_enable  out  1  pipeline clock enable
- out_addr_mem_inst  out  len_addr  instruction memory write address
- out_ins_to_mem  out  len_data  instruction memory write data
- wea_ram_inst  out  1  instruction memory write enable, one-cycle pulse
- tx_start  out  1  one-cycle strobe, send tx_data
- tx_data  out  len_byte  byte to transmit

## Operation
- Commands are single bytes received in IDLE: 0x4C 'L' load, 0x43 'C' continuous, 0x53 'S' step. Any other byte in IDLE is ignored; state unchanged.
- States: IDLE, LD_CNT_H, LD_CNT_L, LD_WORD, LD_WR, RUN, STEP, TX_SEND, TX_WAIT.
- Load:
  - 'L' -> LD_CNT_H. Next byte is the word-count high byte, then LD_CNT_L takes the low byte.
  - Count N = low len_addr bits of {high,low}; upper 5 bits are ignored.
  - N=0 returns to IDLE with no writes.
  - LD_WORD assembles 4 bytes MSB first into out_ins_to_mem, then LD_WR pulses wea_ram_inst for one cycle at the current address.
  - After the write, the address increments and the remaining count decrements. Remaining=0 -> IDLE, else back to LD_WORD.
  - The address starts at 0 on every 'L'. Increment wraps at 2^len_addr-1 -> 0.
- Continuous:
  - 'C' -> RUN. debug_flag=0 and mips_enable=1 each cycle until halt_flag=1.
  - The cycle halt_flag is sampled high, mips_enable drops to 0 and the state goes to TX_SEND.
- Step: 'S' -> STEP. debug_flag=0 and mips_enable=1 for exactly one cycle, then TX_SEND.
- Halted latch:
  - A sticky halted bit is set when halt_flag is seen in RUN or STEP; it clears only on reset.
  - With halted=1, 'C' and 'S' skip RUN/STEP, assert no mips_enable, and go directly to TX_SEND.
- Report:
  - 5 bytes in order: in_pc, in_reg1[31:24], [23:16], [15:8], [7:0].
  - All 5 bytes come from a snapshot captured on entry to TX_SEND.
  - TX_SEND pulses tx_start with tx_data for one cycle, then TX_WAIT waits for tx_done.
  - After byte 5's tx_done, the state returns to IDLE.
- debug_flag=1 in every state except RUN and STEP.
- rx_done is ignored in RUN, STEP, TX_SEND and TX_WAIT.

## Timing
- Reset values:
  - state IDLE, debug_flag=1, mips_enable=0, wea_ram_inst=0, tx_start=0.
  - out_addr_mem_inst=0, out_ins_to_mem=0, tx_data=0.
  - halted=0, byte and word counters=0.
- Byte capture: rx_data is registered in the cycle rx_done=1.
- Write latency: wea_ram_inst is high the cycle after the 4th word byte's rx_done.
  - Address and data are stable during that cycle.
  - The address increments the following cycle.
- A host byte arriving during the LD_WR cycle is accepted, not dropped: LD_WORD byte capture is active in LD_WR as well.
- RUN to report: first tx_start is 2 cycles after the halt_flag sample (transition cycle + snapshot cycle).
- STEP is exactly 1 enabled cycle. The first tx_start is 2 cycles after the STEP cycle.
- tx_done arriving in the same cycle as tx_start is ignored; only TX_WAIT consumes it.
- Reset asserted mid-load or mid-run: all outputs return immediately (asynchronously) to reset values. Partially assembled words are discarded.

## Test plan
- Reset: hold reset=0 with random rx traffic -> debug_flag=1, mips_enable=0, wea_ram_inst=0, tx_start=0. After release, state is IDLE.
- Load 2 words: send 4C,00,02,AA,BB,CC,DD,11,22,33,44 -> two wea_ram_inst pulses: addr 0 data 0xAABBCCDD, then addr 1 data 0x11223344. State IDLE afterwards, debug_flag=1 throughout.
- Load edge cases:
  - 4C,00,00 -> no write pulses.
  - 4C,F8,01 -> N=1; exactly one write at addr 0.
- Step: in_pc=0x08, in_reg1=0x12345678, send 53 -> mips_enable high exactly 1 cycle, debug_flag=0 that cycle. Then 5 bytes 08,12,34,56,78, each released only after tx_done.
- Continuous: send 43, assert halt_flag after 20 cycles -> mips_enable high 20 cycles, then report sent. A second 43 yields a report with zero mips_enable cycles.
- Robustness: send 0x00 and 0x58 in IDLE -> no state change. Send 4C during TX_WAIT -> ignored. Pulse reset mid-word -> next 'L' starts at addr 0 with fresh byte alignment.

Source files
------------

// File: rtl/debug_unit_if.sv
// debug_unit_if: UART byte strobes, pipeline status and
// instruction-memory write port of the bring-up debug unit.
interface debug_unit_if #(
   parameter int len_data = 32,
   parameter int len_addr = 11,
   parameter int len_byte = 8
);
   logic [len_byte-1:0] rx_data;
   logic                rx_done;
   logic                tx_done;
   logic                halt_flag;
   logic [7:0]          in_pc;
   logic [len_data-1:0] in_reg1;
   logic                debug_flag;
   logic                mips_enable;
   logic [len_addr-1:0] out_addr_mem_inst;
   logic [len_data-1:0] out_ins_to_mem;
   logic                wea_ram_inst;
   logic                tx_start;
   logic [len_byte-1:0] tx_data;

   modport master (
      input  rx_data, rx_done, tx_done, halt_flag, in_pc, in_reg1,
      output debug_flag, mips_enable, out_addr_mem_inst,
      output out_ins_to_mem, wea_ram_inst, tx_start, tx_data
   );

   modport slave (
      output rx_data, rx_done, tx_done, halt_flag, in_pc, in_reg1,
      input  debug_flag, mips_enable, out_addr_mem_inst,
      input  out_ins_to_mem, wea_ram_inst, tx_start, tx_data
   );
endinterface

// File: rtl/debug_unit.sv
// debug_unit: host command sequencer for MIPS bring-up.
// Loads program words, runs/steps the pipeline, reports PC/r1.
module debug_unit #(
   parameter int len_data = 32,
   parameter int len_addr = 11,
   parameter int len_byte = 8
) (
   input logic        clk,
   input logic        reset,
   debug_unit_if.master bus
);

   localparam int SNAP_W = 8 + len_data;
   localparam logic [7:0] CMD_L = 8'h4C;
   localparam logic [7:0] CMD_C = 8'h43;
   localparam logic [7:0] CMD_S = 8'h53;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LD_CNT_H,
      S_LD_CNT_L,
      S_LD_WORD,
      S_LD_WR,
      S_RUN,
      S_STEP,
      S_TX_SEND,
      S_TX_WAIT
   } state_t;

   state_t              state_q, state_d;
   logic [len_addr-1:0] addr_q, addr_d;
   logic [len_addr-1:0] cnt_q, cnt_d;
   logic [len_byte-1:0] cnt_h_q, cnt_h_d;
   logic [len_data-1:0] data_q, data_d;
   logic [2:0]          byte_q, byte_d;
   logic                halted_q, halted_d;
   logic [SNAP_W-1:0]   snap_q, snap_d;
   logic                tx_start_q, tx_start_d;
   logic [len_byte-1:0] tx_data_q, tx_data_d;
   logic [len_addr-1:0] cnt_n;
   logic [len_data-1:0] data_sh;

   // State and datapath registers; everything clears on reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         cnt_q      <= '0;
         cnt_h_q    <= '0;
         data_q     <= '0;
         byte_q     <= '0;
         halted_q   <= 1'b0;
         snap_q     <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         cnt_h_q    <= cnt_h_d;
         data_q     <= data_d;
         byte_q     <= byte_d;
         halted_q   <= halted_d;
         snap_q     <= snap_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
      end
   end

   // Next-state and datapath updates for load, run and report.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      cnt_h_d    = cnt_h_q;
      data_d     = data_q;
      byte_d     = byte_q;
      halted_d   = halted_q;
      snap_d     = snap_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      cnt_n      = len_addr'({cnt_h_q, bus.rx_data});
      data_sh    = {data_q[len_data-len_byte-1:0], bus.rx_data};

      unique case (state_q)
         S_IDLE: begin
            if (bus.rx_done) begin
               case (bus.rx_data)
                  CMD_L: begin
                     state_d = S_LD_CNT_H;
                     addr_d  = '0;
                     byte_d  = '0;
                  end
                  CMD_C, CMD_S: begin
                     if (halted_q) begin
                        state_d = S_TX_SEND;
                        snap_d  = {bus.in_pc, bus.in_reg1};
                     end else if (bus.rx_data == CMD_C) begin
                        state_d = S_RUN;
                     end else begin
                        state_d = S_STEP;
                     end
                  end
                  default: ;
               endcase
            end
         end
         S_LD_CNT_H: begin
            if (bus.rx_done) begin
               cnt_h_d = bus.rx_data;
               state_d = S_LD_CNT_L;
            end
         end
         S_LD_CNT_L: begin
            if (bus.rx_done) begin
               if (cnt_n == '0) begin
                  state_d = S_IDLE;
               end else begin
                  cnt_d   = cnt_n;
                  byte_d  = '0;
                  state_d = S_LD_WORD;
               end
            end
         end
         S_LD_WORD: begin
            if (bus.rx_done) begin
               data_d = data_sh;
               if (byte_q == 3'd3) begin
                  byte_d  = '0;
                  state_d = S_LD_WR;
               end else begin
                  byte_d = byte_q + 3'd1;
               end
            end
         end
         S_LD_WR: begin
            // a byte landing here is the first of the next word
            addr_d = addr_q + 1'b1;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == len_addr'(1)) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_LD_WORD;
               if (bus.rx_done) begin
                  data_d = data_sh;
                  byte_d = 3'd1;
               end
            end
         end
         S_RUN: begin
            if (bus.halt_flag) begin
               halted_d = 1'b1;
               snap_d   = {bus.in_pc, bus.in_reg1};
               state_d  = S_TX_SEND;
            end
         end
         S_STEP: begin
            if (bus.halt_flag) begin
               halted_d = 1'b1;
            end
            snap_d  = {bus.in_pc, bus.in_reg1};
            state_d = S_TX_SEND;
         end
         S_TX_SEND: begin
            tx_start_d = 1'b1;
            tx_data_d  = snap_q[SNAP_W-1 -: len_byte];
            snap_d     = snap_q << len_byte;
            state_d    = S_TX_WAIT;
         end
         S_TX_WAIT: begin
            // a done coincident with our own start belongs to no byte
            if (bus.tx_done && !tx_start_q) begin
               if (byte_q == 3'd4) begin
                  byte_d  = '0;
                  state_d = S_IDLE;
               end else begin
                  byte_d  = byte_q + 3'd1;
                  state_d = S_TX_SEND;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.debug_flag = !(state_q == S_RUN ||
                             state_q == S_STEP);
   assign bus.mips_enable = (state_q == S_RUN && !bus.halt_flag) ||
                            state_q == S_STEP;
   assign bus.wea_ram_inst      = (state_q == S_LD_WR);
   assign bus.out_addr_mem_inst = addr_q;
   assign bus.out_ins_to_mem    = data_q;
   assign bus.tx_start          = tx_start_q;
   assign bus.tx_data           = tx_data_q;

endmodule

// File: tb/tb_debug_unit.sv
// tb_debug_unit: directed + randomized checks of debug_unit
// against a transaction-level model of load, step, run, report.
module tb_debug_unit;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   debug_unit_if bus ();

   debug_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [10:0] addr;
      logic [31:0] data;
      int          stamp;
   } wr_t;

   wr_t         exp_wr[$];
   wr_t         got_wr[$];
   logic [7:0]  got_tx[$];
   int          tx_stamp[$];
   logic [31:0] words[$];

   int total   = 0;
   int bad     = 0;
   int ncyc    = 0;
   int en_cnt  = 0;
   int dlo_cnt = 0;
   int viol    = 0;
   int txd     = 0;
   int last_rx = 0;
   int rst_err = 0;
   bit busy     = 1'b0;
   bit m_halted = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bus.rx_data = b;
      bus.rx_done = 1'b1;
      last_rx     = ncyc + 1;
      cyc();
      bus.rx_done = 1'b0;
      repeat (gap) cyc();
   endtask

   task automatic wait_tx(input int n);
      int k;
      k = 0;
      while (got_tx.size() < n && k < 400) begin
         cyc();
         k++;
      end
   endtask

   task automatic check_writes(input string tag);
      chk({tag, "_n"}, 64'(got_wr.size()), 64'(exp_wr.size()));
      foreach (exp_wr[i]) begin
         if (i < got_wr.size()) begin
            chk({tag, "_addr"}, 64'(got_wr[i].addr),
                64'(exp_wr[i].addr));
            chk({tag, "_data"}, 64'(got_wr[i].data),
                64'(exp_wr[i].data));
            chk({tag, "_when"}, 64'(got_wr[i].stamp),
                64'(exp_wr[i].stamp));
         end
      end
      exp_wr.delete();
      got_wr.delete();
   endtask

   // model: N = count mod 2^11 words, word i lands at address i
   task automatic do_load(input logic [15:0] c16, input int gmax,
                          input string tag);
      int n;
      int d0;
      n  = int'(c16[10:0]);
      d0 = dlo_cnt;
      exp_wr.delete();
      got_wr.delete();
      send_byte(8'h4C, $urandom_range(0, gmax));
      send_byte(c16[15:8], $urandom_range(0, gmax));
      send_byte(c16[7:0], $urandom_range(0, gmax));
      for (int i = 0; i < n; i++) begin
         logic [31:0] w;
         w = words[i];
         for (int k = 0; k < 4; k++) begin
            send_byte(w[31-8*k -: 8], $urandom_range(0, gmax));
         end
         exp_wr.push_back('{11'(i), w, last_rx + 1});
      end
      repeat (4) cyc();
      check_writes(tag);
      chk({tag, "_dbg"}, 64'(dlo_cnt - d0), 64'd0);
   endtask

   // model: report = pc, then r1 MSB first; halted skips execution
   task automatic do_report(input logic [7:0] cmd, input int h,
                            input logic [7:0] pc,
                            input logic [31:0] r1, input bit poke,
                            input string tag);
      int en0;
      int d0;
      int ref_stamp;
      int exp_en;
      int exp_dlo;
      logic [7:0] exp_b[5];
      got_tx.delete();
      tx_stamp.delete();
      bus.in_pc   = pc;
      bus.in_reg1 = r1;
      en0 = en_cnt;
      d0  = dlo_cnt;
      exp_b[0] = pc;
      for (int k = 1; k < 5; k++) begin
         exp_b[k] = 8'(r1 >> (8 * (4 - k)));
      end
      send_byte(cmd, 0);
      if (m_halted) begin
         exp_en    = 0;
         exp_dlo   = 0;
         ref_stamp = last_rx + 2;
      end else if (cmd == 8'h53) begin
         exp_en    = 1;
         exp_dlo   = 1;
         ref_stamp = last_rx + 3;
      end else begin
         repeat (h) cyc();
         bus.halt_flag = 1'b1;
         ref_stamp = ncyc + 1 + 2;
         exp_en    = h;
         exp_dlo   = h + 1;
         cyc();
         bus.halt_flag = 1'b0;
         m_halted = 1'b1;
      end
      if (poke) begin
         wait_tx(1);
         send_byte(8'h4C, 0);
      end
      wait_tx(5);
      repeat (6) cyc();
      chk({tag, "_nbytes"}, 64'(got_tx.size()), 64'd5);
      chk({tag, "_en"}, 64'(en_cnt - en0), 64'(exp_en));
      chk({tag, "_dbg"}, 64'(dlo_cnt - d0), 64'(exp_dlo));
      for (int k = 0; k < 5; k++) begin
         if (k < got_tx.size()) begin
            chk({tag, "_byte"}, 64'(got_tx[k]), 64'(exp_b[k]));
         end
      end
      if (tx_stamp.size() > 0) begin
         chk({tag, "_lat"}, 64'(tx_stamp[0]), 64'(ref_stamp));
      end
   endtask

   // monitor and UART tx responder, sampled mid-cycle
   initial begin
      bus.tx_done = 1'b0;
      forever begin
         @(negedge clk);
         ncyc++;
         bus.tx_done = 1'b0;
         if (bus.wea_ram_inst) begin
            got_wr.push_back('{bus.out_addr_mem_inst,
                               bus.out_ins_to_mem, ncyc});
         end
         if (bus.mips_enable) en_cnt++;
         if (!bus.debug_flag) dlo_cnt++;
         if (bus.tx_start) begin
            got_tx.push_back(bus.tx_data);
            tx_stamp.push_back(ncyc);
            if (busy) viol++;
            busy = 1'b1;
            txd  = $urandom_range(2, 4);
            if ($urandom_range(0, 1) == 1) bus.tx_done = 1'b1;
         end else if (txd > 0) begin
            txd--;
            if (txd == 0) begin
               bus.tx_done = 1'b1;
               busy = 1'b0;
            end
         end
      end
   end

   initial begin
      logic [31:0] w1;
      int n;
      bus.rx_data   = '0;
      bus.rx_done   = 1'b0;
      bus.halt_flag = 1'b0;
      bus.in_pc     = '0;
      bus.in_reg1   = '0;
      reset         = 1'b0;

      repeat (8) begin
         cyc();
         bus.rx_done = 1'($urandom_range(0, 1));
         bus.rx_data = 8'($urandom);
         if (bus.wea_ram_inst || bus.tx_start ||
             bus.mips_enable || !bus.debug_flag) rst_err++;
      end
      chk("rst_ctrl", 64'(rst_err), 64'd0);
      chk("rst_addr", 64'(bus.out_addr_mem_inst), 64'd0);
      chk("rst_ins", 64'(bus.out_ins_to_mem), 64'd0);
      chk("rst_txd", 64'(bus.tx_data), 64'd0);
      bus.rx_done = 1'b0;
      cyc();
      reset = 1'b1;
      cyc();

      got_wr.delete();
      got_tx.delete();
      n = en_cnt;
      send_byte(8'h00, 1);
      send_byte(8'h58, 1);
      repeat (5) cyc();
      chk("junk_wr", 64'(got_wr.size()), 64'd0);
      chk("junk_tx", 64'(got_tx.size()), 64'd0);
      chk("junk_en", 64'(en_cnt - n), 64'd0);

      words = '{32'hAABBCCDD, 32'h11223344};
      do_load(16'h0002, 0, "ld2");
      words.delete();
      do_load(16'h0000, 0, "ld0");
      words = '{$urandom};
      do_load(16'hF801, 2, "ldf8");
      for (int r = 0; r < 3; r++) begin
         n = $urandom_range(1, 6);
         words.delete();
         for (int i = 0; i < n; i++) words.push_back($urandom);
         do_load({5'($urandom), 11'(n)}, 2, "ldr");
      end

      w1 = $urandom;
      send_byte(8'h4C, 0);
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      for (int k = 0; k < 4; k++) send_byte(w1[31-8*k -: 8], 0);
      send_byte(8'hA5, 0);
      send_byte(8'h5A, 0);
      reset = 1'b0;
      #1;
      chk("arst_wea", 64'(bus.wea_ram_inst), 64'd0);
      chk("arst_addr", 64'(bus.out_addr_mem_inst), 64'd0);
      chk("arst_ins", 64'(bus.out_ins_to_mem), 64'd0);
      chk("arst_dbg", 64'(bus.debug_flag), 64'd1);
      cyc();
      cyc();
      reset = 1'b1;
      cyc();
      words = '{$urandom};
      do_load(16'h0001, 1, "ld_after_rst");

      do_report(8'h53, 0, 8'h08, 32'h12345678, 1'b1, "step");
      for (int r = 0; r < 2; r++) begin
         do_report(8'h53, 0, 8'($urandom), $urandom, 1'b0, "step_r");
      end
      do_report(8'h43, 20, 8'($urandom), $urandom, 1'b0, "run20");
      do_report(8'h43, 0, 8'($urandom), $urandom, 1'b0, "run_hlt");
      do_report(8'h53, 0, 8'($urandom), $urandom, 1'b0, "step_hlt");

      reset = 1'b0;
      cyc();
      reset = 1'b1;
      m_halted = 1'b0;
      cyc();
      do_report(8'h43, $urandom_range(3, 25), 8'($urandom), $urandom,
                1'b0, "run_r");
      chk("tx_proto", 64'(viol), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
